// File: rtl/mem_pkg.sv
// +-----------------------------------------------------------------------+
// | mem_pkg: shared widths, FSM states and owner encoding for mem_arbiter |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

package mem_pkg;

  localparam int MEM_ADDR_W = 14;
  localparam int MEM_LINE_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WB_REQ  = 3'd1,
    ST_WB_WAIT = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter.sv
// +-----------------------------------------------------------------------+
// | mem_arbiter: I/D-cache line-miss arbiter driving unified_mem          |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int LINE_W = MEM_LINE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_dirty,
  input  logic [ADDR_W-1:0] d_wb_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_done,
  output logic [LINE_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rd_data,
  input  logic              mem_rdy,
  output logic              busy
);

  state_e              r_state;
  owner_e              r_owner;
  logic [ADDR_W-1:0]   r_fill_addr;

  // Strobes come straight from the state register, so each is exactly one
  // cycle wide and the two can never overlap.
  assign mem_we = (r_state == ST_WB_REQ);
  assign mem_re = (r_state == ST_RD_REQ);
  assign busy   = (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_I;
      r_fill_addr <= '0;
      i_done      <= 1'b0;
      d_done      <= 1'b0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // mem_addr/mem_wdata are loaded here so they are stable in the
          // following strobe cycle; D has fixed priority over I.
          if (mem_rdy && (d_req || i_req)) begin
            if (d_req) begin
              r_owner     <= OWN_D;
              r_fill_addr <= d_addr;
              if (d_dirty) begin
                mem_addr  <= d_wb_addr;
                mem_wdata <= d_wdata;
                r_state   <= ST_WB_REQ;
              end else begin
                mem_addr  <= d_addr;
                r_state   <= ST_RD_REQ;
              end
            end else begin
              r_owner     <= OWN_I;
              r_fill_addr <= i_addr;
              mem_addr    <= i_addr;
              r_state     <= ST_RD_REQ;
            end
          end
        end
        ST_WB_REQ: r_state <= ST_WB_WAIT;
        ST_WB_WAIT: begin
          if (mem_rdy) begin
            mem_addr <= r_fill_addr;
            r_state  <= ST_RD_REQ;
          end
        end
        ST_RD_REQ: r_state <= ST_RD_WAIT;
        ST_RD_WAIT: begin
          if (mem_rdy) begin
            if (r_owner == OWN_D) begin
              d_rdata <= mem_rd_data;
              d_done  <= 1'b1;
            end else begin
              i_rdata <= mem_rd_data;
              i_done  <= 1'b1;
            end
            r_state <= ST_DONE;
          end
        end
        // Requests are deliberately not sampled here.
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// +-----------------------------------------------------------------------+
// | tb_mem_arbiter: directed self-checking bench with a unified_mem model |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int AW = MEM_ADDR_W;
  localparam int LW = MEM_LINE_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_done;
  logic [LW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic          d_dirty = 1'b0;
  logic [AW-1:0] d_wb_addr = '0;
  logic [LW-1:0] d_wdata = '0;
  logic          d_done;
  logic [LW-1:0] d_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic          mem_we;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rd_data;
  logic          mem_rdy;

  logic          busy;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_dirty(d_dirty), .d_wb_addr(d_wb_addr),
    .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rd_data(mem_rd_data), .mem_rdy(mem_rdy), .busy(busy)
  );

  // Memory model: rdy drops in the strobe cycle, returns in the 4th cycle after.
  logic [LW-1:0] mem_q [0:(1<<AW)-1];
  logic [LW-1:0] rd_q = '0;
  int            mcnt = 0;
  logic          force_low = 1'b0;

  assign mem_rdy     = !force_low && (mcnt <= 1) && !(mem_re || mem_we);
  assign mem_rd_data = rd_q;

  always @(posedge clk) begin
    if (mem_we) mem_q[mem_addr] <= mem_wdata;
    if (mem_re) rd_q <= mem_q[mem_addr];
    if (mem_re || mem_we) mcnt <= 4;
    else if (mcnt > 0) mcnt <= mcnt - 1;
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int grant_cyc = 0;
  int n_re = 0, n_we = 0, n_idone = 0, n_ddone = 0, n_overlap = 0, n_long = 0;
  logic [AW-1:0] last_re_addr = '0, last_we_addr = '0;
  logic [LW-1:0] last_we_data = '0;
  logic prev_re = 1'b0, prev_we = 1'b0, prev_busy = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mem_re && mem_we) n_overlap++;
    if ((mem_re && prev_re) || (mem_we && prev_we)) n_long++;
    if (mem_re) begin n_re++; last_re_addr = mem_addr; end
    if (mem_we) begin n_we++; last_we_addr = mem_addr; last_we_data = mem_wdata; end
    if (i_done) n_idone++;
    if (d_done) n_ddone++;
    if (busy && !prev_busy) grant_cyc = cyc - 1;
    prev_re   = mem_re;
    prev_we   = mem_we;
    prev_busy = busy;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input bit is_d, output int t);
    bit seen;
    seen = 1'b0;
    t = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if ((is_d ? d_done : i_done) === 1'b1) begin
        seen = 1'b1;
        t = cyc;
        break;
      end
    end
    check(is_d ? "d_done_seen" : "i_done_seen", {63'd0, seen}, 64'd1);
  endtask

  int t_i, t_d, b_re, b_i, b_d;
  bit got_we;

  initial begin
    mem_q[14'h0010] = 64'h4444_3333_2222_1111;
    mem_q[14'h0030] = 64'h0303_0303_0303_0303;
    mem_q[14'h0040] = 64'h4040_4040_0000_0001;
    mem_q[14'h0050] = 64'h5050_5050_0000_0002;
    mem_q[14'h0060] = 64'h6060_0000_0000_0003;
    mem_q[14'h0061] = 64'h6161_0000_0000_0004;
    mem_q[14'h0071] = 64'h7171_0000_0000_0005;
    mem_q[14'h0080] = 64'h8080_0000_0000_0006;

    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_strobes", {62'd0, mem_re, mem_we}, 64'd0);
    check("rst_dones", {62'd0, i_done, d_done}, 64'd0);
    check("rst_mem_addr", {50'd0, mem_addr}, 64'd0);
    check("rst_i_rdata", i_rdata, 64'd0);
    rst_n = 1'b1;

    // Clean I fill
    @(negedge clk);
    i_req = 1'b1; i_addr = 14'h0010;
    wait_done(1'b0, t_i);
    i_req = 1'b0;
    check("clean_lat", t_i - grant_cyc, 6);
    check("clean_rdata", i_rdata, 64'h4444_3333_2222_1111);
    repeat (3) @(negedge clk);
    check("clean_re_cnt", n_re, 1);
    check("clean_re_addr", {50'd0, last_re_addr}, 64'h10);
    check("clean_no_we", n_we, 0);
    check("clean_no_ddone", n_ddone, 0);

    // Dirty D miss
    d_req = 1'b1; d_dirty = 1'b1; d_wb_addr = 14'h0020;
    d_wdata = 64'hDEAD_BEEF_CAFE_F00D; d_addr = 14'h0030;
    wait_done(1'b1, t_d);
    d_req = 1'b0; d_dirty = 1'b0;
    check("dirty_lat", t_d - grant_cyc, 11);
    check("dirty_rdata", d_rdata, 64'h0303_0303_0303_0303);
    repeat (3) @(negedge clk);
    check("dirty_we_cnt", n_we, 1);
    check("dirty_we_addr", {50'd0, last_we_addr}, 64'h20);
    check("dirty_we_data", last_we_data, 64'hDEAD_BEEF_CAFE_F00D);
    check("dirty_re_addr", {50'd0, last_re_addr}, 64'h30);
    check("dirty_no_idone", n_idone, 1);
    i_req = 1'b1; i_addr = 14'h0020;
    wait_done(1'b0, t_i);
    i_req = 1'b0;
    check("wb_readback", i_rdata, 64'hDEAD_BEEF_CAFE_F00D);
    repeat (3) @(negedge clk);

    // Simultaneous requests: D first, I granted right after DONE
    i_req = 1'b1; i_addr = 14'h0040;
    d_req = 1'b1; d_addr = 14'h0050;
    wait_done(1'b1, t_d);
    d_req = 1'b0;
    wait_done(1'b0, t_i);
    i_req = 1'b0;
    check("prio_gap", t_i - t_d, 7);
    check("prio_d_rdata", d_rdata, 64'h5050_5050_0000_0002);
    check("prio_i_rdata", i_rdata, 64'h4040_4040_0000_0001);
    repeat (3) @(negedge clk);

    // Back-to-back I requests
    b_re = n_re; b_i = n_idone; b_d = n_ddone;
    i_req = 1'b1; i_addr = 14'h0060;
    wait_done(1'b0, t_i);
    i_req = 1'b0;
    check("b2b_first_rdata", i_rdata, 64'h6060_0000_0000_0003);
    @(negedge clk);
    i_req = 1'b1; i_addr = 14'h0061;
    wait_done(1'b0, t_i);
    i_req = 1'b0;
    repeat (4) @(negedge clk);
    check("b2b_re_cnt", n_re - b_re, 2);
    check("b2b_idone_cnt", n_idone - b_i, 2);
    check("b2b_no_ddone", n_ddone - b_d, 0);
    check("b2b_rdata", i_rdata, 64'h6161_0000_0000_0004);
    check("strobe_overlap", n_overlap, 0);
    check("strobe_width", n_long, 0);

    // Reset during WB_WAIT
    b_d = n_ddone;
    d_req = 1'b1; d_dirty = 1'b1; d_wb_addr = 14'h0070;
    d_wdata = 64'h1234_5678_9ABC_DEF0; d_addr = 14'h0071;
    got_we = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_we) begin got_we = 1'b1; break; end
    end
    check("rstmid_we_seen", {63'd0, got_we}, 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_busy", {63'd0, busy}, 64'd0);
    check("rstmid_mem_addr", {50'd0, mem_addr}, 64'd0);
    check("rstmid_mem_wdata", mem_wdata, 64'd0);
    check("rstmid_d_rdata", d_rdata, 64'd0);
    check("rstmid_i_rdata", i_rdata, 64'd0);
    d_req = 1'b0; d_dirty = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b1;
    check("rstmid_no_done", n_ddone - b_d, 0);
    @(negedge clk);
    d_req = 1'b1; d_addr = 14'h0071;
    wait_done(1'b1, t_d);
    d_req = 1'b0;
    check("post_rst_lat", t_d - grant_cyc, 6);
    check("post_rst_rdata", d_rdata, 64'h7171_0000_0000_0005);
    repeat (3) @(negedge clk);

    // mem_rdy held low in IDLE
    force_low = 1'b1;
    b_re = n_re;
    i_req = 1'b1; i_addr = 14'h0080;
    repeat (5) @(negedge clk);
    check("rdylow_busy", {63'd0, busy}, 64'd0);
    check("rdylow_no_re", n_re - b_re, 0);
    force_low = 1'b0;
    @(negedge clk);
    check("rdyup_busy", {63'd0, busy}, 64'd1);
    check("rdyup_re", {63'd0, mem_re}, 64'd1);
    wait_done(1'b0, t_i);
    i_req = 1'b0;
    check("rdyup_lat", t_i - grant_cyc, 6);
    check("rdyup_rdata", i_rdata, 64'h8080_0000_0000_0006);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Initiator side of the unified-memory protocol. It takes line-miss requests from the I-cache (fill only) and the D-cache (fill, with optional dirty-line writeback first). It arbitrates between the two and sequences single-line read/write transactions into unified_mem. It returns each 64-bit fill line to the requesting cache with a one-cycle done pulse.

Parameters:
ADDR_W, 14, line address width (memory word address with 2 LSBs dropped)
LINE_W, 64, cache line / memory data width

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
i_req  input  1  I-cache miss request; held high until i_done
i_addr  input  ADDR_W  I-cache fill line address
i_done  output  1  one-cycle pulse: i_rdata valid
i_rdata  output  LINE_W  fill line for I-cache
d_req  input  1  D-cache miss request; held high until d_done
d_addr  input  ADDR_W  D-cache fill line address
d_dirty  input  1  evicted line dirty; writeback required before fill
d_wb_addr  input  ADDR_W  writeback line address
d_wdata  input  LINE_W  writeback line data
d_done  output  1  one-cycle pulse: d_rdata valid
d_rdata  output  LINE_W  fill line for D-cache
mem_addr  output  ADDR_W  to memory addr
mem_re  output  1  memory read strobe, exactly one cycle per read
mem_we  output  1  memory write strobe, exactly one cycle per write
mem_wdata  output  LINE_W  memory write data
mem_rd_data  input  LINE_W  memory read data
mem_rdy  input  1  memory ready; high when idle or completing an access
busy  output  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE. i_done, d_done, mem_re, mem_we, busy = 0. i_rdata, d_rdata, mem_addr, mem_wdata and latched fields = 0. Reset mid-transaction aborts silently; no done pulse is issued.
- Memory protocol (initiator rules):
  - Issue a strobe only in a cycle with mem_rdy=1 while the arbiter is in IDLE-equivalent protocol phase.
  - Strobe is high for exactly one cycle, and mem_re and mem_we are never high together.
  - mem_rdy drops combinationally in the strobe cycle.
  - The access completes in the first WAIT cycle with mem_rdy=1, which is the 4th cycle after the strobe cycle. mem_rd_data is sampled at the posedge ending that cycle.
- States: IDLE, WB_REQ, WB_WAIT, RD_REQ, RD_WAIT, DONE.
- IDLE:
  - With mem_rdy=1 and any request, grant and latch owner, addresses, d_dirty and d_wdata.
  - Fixed priority: d_req beats i_req when both are high.
  - Next state is WB_REQ if the D owner has d_dirty=1, else RD_REQ.
  - If mem_rdy=0, stay in IDLE.
- WB_REQ: mem_we=1, mem_addr=latched wb_addr, mem_wdata=latched wdata. Next state WB_WAIT.
- WB_WAIT: stay while mem_rdy=0; on mem_rdy=1 go to RD_REQ.
- RD_REQ: mem_re=1, mem_addr=latched fill addr. Next state RD_WAIT.
- RD_WAIT: on mem_rdy=1, register mem_rd_data into the owner's rdata and go to DONE.
- DONE:
  - Owner's done=1 for this single cycle; rdata holds until the next fill for that owner.
  - Next state IDLE. Requests are ignored in DONE, so a client dropping req at this edge is never double-served.
- Latency from the grant cycle to the done cycle: clean fill 6 cycles; dirty D fill 11 cycles.
- mem_addr and mem_wdata hold their last value outside strobe cycles. mem_re and mem_we are decoded from state.
- Starvation: fixed priority is accepted, because a pending D miss stalls the pipeline and so does not stream continuously.
- A request dropped before done is a client protocol violation and is not handled. The transaction still completes and pulses done.

Decomposition:
- Package mem_pkg:
  - ADDR_W and LINE_W defaults.
  - State enum/localparams for the six states.
  - Owner encoding (OWN_I=0, OWN_D=1).
- Single module; no sub-module warranted.

Test Plan:
- Clean I fill: i_req, i_addr=14'h0010; mem preloaded with 64'h4444_3333_2222_1111 -> mem_re for 1 cycle at addr 0x0010; i_done pulses 6 cycles after grant with i_rdata=64'h4444_3333_2222_1111; d_done stays 0.
- Dirty D miss: d_req, d_dirty=1, d_wb_addr=0x0020, d_wdata=64'hDEAD_BEEF_CAFE_F00D, d_addr=0x0030 -> mem_we at 0x0020, then mem_re at 0x0030. d_done arrives 11 cycles after grant. A later read of 0x0020 returns 64'hDEAD_BEEF_CAFE_F00D.
- Simultaneous i_req and d_req (clean) -> D is served first (d_done). I is granted in the IDLE cycle after DONE. i_done follows 7 cycles after d_done.
- Back-to-back: client re-raises i_req the cycle after i_done with a new address -> exactly one mem_re per request and no duplicate done. Check mem_re and mem_we are never high together and each strobe is one cycle.
- Reset asserted during WB_WAIT -> all outputs return to reset values asynchronously; no done pulse. After release, a fresh d_req completes normally.
- mem_rdy forced low in IDLE with i_req pending -> no strobe issued and state stays IDLE. Raising mem_rdy starts the fill on the next cycle.
